// File: rtl/sv_conv_group_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sv_conv_group_sequencer
//  Description : Layer-level controller that walks the output-storage stage
//                through every filter group of one convolution layer. For
//                each group it programs the storage start offset, opens a
//                one-cycle reinit window, then releases the datapath until
//                storage reports conv_complete. The layer configuration is
//                latched at start and held for the whole layer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sv_conv_group_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DIM_WIDTH      = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int MACS_PER_GROUP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  cfg_num_filters,
    input  logic [ADDR_WIDTH-1:0] cfg_base_offset,
    input  logic [ADDR_WIDTH-1:0] cfg_elements_per_channel,
    input  logic [DIM_WIDTH-1:0]  cfg_output_w,
    input  logic [DIM_WIDTH-1:0]  cfg_output_h,
    input  logic                  cfg_max_pooling,
    input  logic                  conv_complete,
    output logic                  conv_idle,
    output logic [ADDR_WIDTH-1:0] initial_offset,
    output logic [ADDR_WIDTH-1:0] elements_per_channel,
    output logic [DIM_WIDTH-1:0]  output_w,
    output logic [DIM_WIDTH-1:0]  output_h,
    output logic                  max_pooling,
    output logic                  group_start,
    output logic [CNT_WIDTH-1:0]  group_idx,
    output logic                  busy,
    output logic                  layer_done
);

    // MACS_PER_GROUP is a power of two, so division and multiplication by it
    // reduce to shifts.
    localparam int c_SHIFT = $clog2(MACS_PER_GROUP);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_RUN     = 3'd2;
    localparam logic [2:0] c_ST_ADVANCE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]            r_state;
    logic                  r_conv_idle;
    logic [ADDR_WIDTH-1:0] r_initial_offset;
    logic [ADDR_WIDTH-1:0] r_elements_per_channel;
    logic [DIM_WIDTH-1:0]  r_output_w;
    logic [DIM_WIDTH-1:0]  r_output_h;
    logic                  r_max_pooling;
    logic                  r_group_start;
    logic [CNT_WIDTH-1:0]  r_group_idx;
    logic [CNT_WIDTH-1:0]  r_last_group;
    logic                  r_busy;
    logic                  r_layer_done;

    // Index of the final group is (n-1)/M, i.e. ceil(n/M)-1, which cannot
    // overflow for any nonzero n. Only used when cfg_num_filters != 0.
    logic [CNT_WIDTH-1:0]  w_last_group;
    logic [ADDR_WIDTH-1:0] w_stride;

    assign w_last_group = (cfg_num_filters - CNT_WIDTH'(1)) >> c_SHIFT;
    assign w_stride     = r_elements_per_channel << c_SHIFT;

    // Layer sequencing FSM; every output is updated alongside the state so
    // it is valid on the same cycle the state becomes current.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                <= c_ST_IDLE;
            r_conv_idle            <= 1'b1;
            r_initial_offset       <= '0;
            r_elements_per_channel <= '0;
            r_output_w             <= '0;
            r_output_h             <= '0;
            r_max_pooling          <= 1'b0;
            r_group_start          <= 1'b0;
            r_group_idx            <= '0;
            r_last_group           <= '0;
            r_busy                 <= 1'b0;
            r_layer_done           <= 1'b0;
        end else begin
            r_group_start <= 1'b0;
            r_layer_done  <= 1'b0;
            if (abort) begin
                // Abort drops to IDLE silently; configuration and progress hold.
                r_state     <= c_ST_IDLE;
                r_conv_idle <= 1'b1;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_conv_idle <= 1'b1;
                        if (start) begin
                            if (cfg_num_filters != '0) begin
                                r_elements_per_channel <= cfg_elements_per_channel;
                                r_output_w             <= cfg_output_w;
                                r_output_h             <= cfg_output_h;
                                r_max_pooling          <= cfg_max_pooling;
                                r_initial_offset       <= cfg_base_offset;
                                r_group_idx            <= '0;
                                r_last_group           <= w_last_group;
                                r_busy                 <= 1'b1;
                                r_state                <= c_ST_SETUP;
                            end else begin
                                // Empty layer: report completion without latching.
                                r_layer_done <= 1'b1;
                            end
                        end
                    end
                    c_ST_SETUP: begin
                        r_conv_idle   <= 1'b0;
                        r_group_start <= 1'b1;
                        r_state       <= c_ST_RUN;
                    end
                    c_ST_RUN: begin
                        // group_start marks the first RUN cycle, where a
                        // complete is still the previous group's stale flag.
                        if (conv_complete && !r_group_start) begin
                            r_conv_idle <= 1'b1;
                            if (r_group_idx == r_last_group) begin
                                r_layer_done <= 1'b1;
                                r_state      <= c_ST_DONE;
                            end else begin
                                r_initial_offset <= r_initial_offset + w_stride;
                                r_group_idx      <= r_group_idx + CNT_WIDTH'(1);
                                r_state          <= c_ST_ADVANCE;
                            end
                        end
                    end
                    c_ST_ADVANCE: begin
                        r_conv_idle   <= 1'b0;
                        r_group_start <= 1'b1;
                        r_state       <= c_ST_RUN;
                    end
                    c_ST_DONE: begin
                        r_conv_idle <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                    default: begin
                        r_conv_idle <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign conv_idle            = r_conv_idle;
    assign initial_offset       = r_initial_offset;
    assign elements_per_channel = r_elements_per_channel;
    assign output_w             = r_output_w;
    assign output_h             = r_output_h;
    assign max_pooling          = r_max_pooling;
    assign group_start          = r_group_start;
    assign group_idx            = r_group_idx;
    assign busy                 = r_busy;
    assign layer_done           = r_layer_done;

endmodule
`default_nettype wire

// File: tb/tb_sv_conv_group_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sv_conv_group_sequencer
//  Description : Directed self-checking bench for sv_conv_group_sequencer.
//                Inputs change and outputs are sampled 1 time unit after
//                each rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sv_conv_group_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] cfg_num_filters;
    logic [31:0] cfg_base_offset;
    logic [31:0] cfg_elements_per_channel;
    logic [7:0]  cfg_output_w;
    logic [7:0]  cfg_output_h;
    logic        cfg_max_pooling;
    logic        conv_complete;
    logic        conv_idle;
    logic [31:0] initial_offset;
    logic [31:0] elements_per_channel;
    logic [7:0]  output_w;
    logic [7:0]  output_h;
    logic        max_pooling;
    logic        group_start;
    logic [15:0] group_idx;
    logic        busy;
    logic        layer_done;

    int n_cmp = 0;
    int n_err = 0;

    sv_conv_group_sequencer #(
        .ADDR_WIDTH    (32),
        .DIM_WIDTH     (8),
        .CNT_WIDTH     (16),
        .MACS_PER_GROUP(4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .abort                   (abort),
        .cfg_num_filters         (cfg_num_filters),
        .cfg_base_offset         (cfg_base_offset),
        .cfg_elements_per_channel(cfg_elements_per_channel),
        .cfg_output_w            (cfg_output_w),
        .cfg_output_h            (cfg_output_h),
        .cfg_max_pooling         (cfg_max_pooling),
        .conv_complete           (conv_complete),
        .conv_idle               (conv_idle),
        .initial_offset          (initial_offset),
        .elements_per_channel    (elements_per_channel),
        .output_w                (output_w),
        .output_h                (output_h),
        .max_pooling             (max_pooling),
        .group_start             (group_start),
        .group_idx               (group_idx),
        .busy                    (busy),
        .layer_done              (layer_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compact check of the handshake outputs: conv_idle, busy, group_start, layer_done.
    task automatic chk_ctl(input string tag, input logic ci, input logic bz, input logic gs, input logic ld);
        chk({tag, ".conv_idle"},   32'(conv_idle),   32'(ci));
        chk({tag, ".busy"},        32'(busy),        32'(bz));
        chk({tag, ".group_start"}, 32'(group_start), 32'(gs));
        chk({tag, ".layer_done"},  32'(layer_done),  32'(ld));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; conv_complete = 1'b0;
        cfg_num_filters = '0; cfg_base_offset = '0; cfg_elements_per_channel = '0;
        cfg_output_w = '0; cfg_output_h = '0; cfg_max_pooling = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // ---------------- reset / idle for 10 cycles ----------------
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_ctl("idle", 1, 0, 0, 0);
            chk("idle.offset", initial_offset, 32'h0);
            chk("idle.idx", 32'(group_idx), 32'h0);
            chk("idle.epc", elements_per_channel, 32'h0);
            chk("idle.pool", 32'(max_pooling), 32'h0);
        end

        // ---------------- 8 filters, base 0, epc 100 ----------------
        cfg_num_filters = 16'd8; cfg_base_offset = 32'd0; cfg_elements_per_channel = 32'd100;
        cfg_output_w = 8'd10; cfg_output_h = 8'd10; cfg_max_pooling = 1'b0;
        start = 1'b1;
        tick();                                        // SETUP
        start = 1'b0;
        chk_ctl("t2.setup", 1, 1, 0, 0);
        chk("t2.setup.epc", elements_per_channel, 32'd100);
        chk("t2.setup.w", 32'(output_w), 32'd10);
        tick();                                        // RUN g0
        chk_ctl("t2.run0", 0, 1, 1, 0);
        chk("t2.run0.offset", initial_offset, 32'd0);
        chk("t2.run0.idx", 32'(group_idx), 32'd0);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk_ctl("t2.run0.wait", 0, 1, 0, 0);
        end
        conv_complete = 1'b1;
        tick();                                        // ADVANCE
        conv_complete = 1'b0;
        chk_ctl("t2.adv", 1, 1, 0, 0);
        chk("t2.adv.offset", initial_offset, 32'd400);
        chk("t2.adv.idx", 32'(group_idx), 32'd1);
        tick();                                        // RUN g1
        chk_ctl("t2.run1", 0, 1, 1, 0);
        chk("t2.run1.offset", initial_offset, 32'd400);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk_ctl("t2.run1.wait", 0, 1, 0, 0);
        end
        conv_complete = 1'b1;
        tick();                                        // DONE
        conv_complete = 1'b0;
        chk_ctl("t2.done", 1, 1, 0, 1);
        tick();                                        // IDLE
        chk_ctl("t2.idle", 1, 0, 0, 0);
        chk("t2.idle.offset", initial_offset, 32'd400);
        chk("t2.idle.idx", 32'(group_idx), 32'd1);

        // ---------------- 6 filters, pooling, cfg churn mid-layer ----------------
        cfg_num_filters = 16'd6; cfg_base_offset = 32'h10; cfg_elements_per_channel = 32'h40;
        cfg_output_w = 8'd5; cfg_output_h = 8'd6; cfg_max_pooling = 1'b1;
        start = 1'b1;
        tick();                                        // SETUP
        start = 1'b0;
        chk("t3.setup.offset", initial_offset, 32'h10);
        chk("t3.setup.pool", 32'(max_pooling), 32'h1);
        chk("t3.setup.h", 32'(output_h), 32'd6);
        chk("t3.setup.idx", 32'(group_idx), 32'd0);
        cfg_num_filters = 16'd100; cfg_base_offset = 32'hFFFF; cfg_elements_per_channel = 32'd7;
        cfg_output_w = 8'd1; cfg_output_h = 8'd2; cfg_max_pooling = 1'b0;
        tick();                                        // RUN g0 first cycle
        chk_ctl("t3.run0", 0, 1, 1, 0);
        tick();                                        // RUN g0 second cycle
        conv_complete = 1'b1;
        tick();                                        // ADVANCE
        conv_complete = 1'b0;
        chk("t3.adv.offset", initial_offset, 32'h110);
        chk("t3.adv.idx", 32'(group_idx), 32'd1);
        chk("t3.adv.pool", 32'(max_pooling), 32'h1);
        chk("t3.adv.epc", elements_per_channel, 32'h40);
        chk("t3.adv.w", 32'(output_w), 32'd5);
        tick();                                        // RUN g1
        tick();
        conv_complete = 1'b1;
        tick();                                        // DONE (2 groups, not 25)
        conv_complete = 1'b0;
        chk_ctl("t3.done", 1, 1, 0, 1);
        tick();
        chk_ctl("t3.idle", 1, 0, 0, 0);

        // ---------------- zero filters ----------------
        cfg_num_filters = 16'd0; cfg_base_offset = 32'h5555; cfg_max_pooling = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("t4.pulse", 1, 0, 0, 1);
        chk("t4.nolatch.pool", 32'(max_pooling), 32'h1);
        chk("t4.nolatch.offset", initial_offset, 32'h110);
        tick();
        chk_ctl("t4.after", 1, 0, 0, 0);

        // ---------------- conv_complete held high, 3 groups ----------------
        cfg_num_filters = 16'd12; cfg_base_offset = 32'h1000; cfg_elements_per_channel = 32'd2;
        cfg_output_w = 8'd7; cfg_output_h = 8'd8; cfg_max_pooling = 1'b0;
        start = 1'b1;
        tick();                                        // 1: SETUP
        start = 1'b0;
        conv_complete = 1'b1;
        chk_ctl("t5.setup", 1, 1, 0, 0);
        tick();                                        // 2: RUN g0 first (stale)
        chk_ctl("t5.run0a", 0, 1, 1, 0);
        tick();                                        // 3: RUN g0 second
        chk_ctl("t5.run0b", 0, 1, 0, 0);
        tick();                                        // 4: ADVANCE
        chk_ctl("t5.adv1", 1, 1, 0, 0);
        chk("t5.adv1.offset", initial_offset, 32'h1008);
        tick();                                        // 5: RUN g1 first
        chk_ctl("t5.run1a", 0, 1, 1, 0);
        tick();                                        // 6: RUN g1 second
        chk_ctl("t5.run1b", 0, 1, 0, 0);
        tick();                                        // 7: ADVANCE
        chk("t5.adv2.offset", initial_offset, 32'h1010);
        chk("t5.adv2.idx", 32'(group_idx), 32'd2);
        tick();                                        // 8: RUN g2 first
        chk_ctl("t5.run2a", 0, 1, 1, 0);
        tick();                                        // 9: RUN g2 second
        chk_ctl("t5.run2b", 0, 1, 0, 0);
        tick();                                        // 10: DONE
        chk_ctl("t5.done", 1, 1, 0, 1);
        conv_complete = 1'b0;
        tick();
        chk_ctl("t5.idle", 1, 0, 0, 0);

        // ---------------- abort in group 1, then restart ----------------
        cfg_num_filters = 16'd8; cfg_base_offset = 32'h20; cfg_elements_per_channel = 32'd1;
        start = 1'b1;
        tick();                                        // SETUP
        start = 1'b0;
        tick();                                        // RUN g0 first
        tick();                                        // RUN g0 second
        conv_complete = 1'b1;
        tick();                                        // ADVANCE
        conv_complete = 1'b0;
        chk("t6.adv.offset", initial_offset, 32'h24);
        tick();                                        // RUN g1
        chk_ctl("t6.run1", 0, 1, 1, 0);
        abort = 1'b1;
        tick();                                        // IDLE
        chk_ctl("t6.abort", 1, 0, 0, 0);
        chk("t6.abort.idx", 32'(group_idx), 32'd1);
        chk("t6.abort.offset", initial_offset, 32'h24);
        start = 1'b1;                                  // abort wins over start
        cfg_num_filters = 16'd4; cfg_base_offset = 32'h300;
        tick();
        chk_ctl("t6.abortstart", 1, 0, 0, 0);
        chk("t6.abortstart.offset", initial_offset, 32'h24);
        abort = 1'b0;
        tick();                                        // SETUP
        start = 1'b0;
        chk_ctl("t6.re.setup", 1, 1, 0, 0);
        chk("t6.re.offset", initial_offset, 32'h300);
        chk("t6.re.idx", 32'(group_idx), 32'd0);
        tick();                                        // RUN g0
        chk_ctl("t6.re.run", 0, 1, 1, 0);
        tick();
        conv_complete = 1'b1;
        tick();                                        // DONE (single group)
        conv_complete = 1'b0;
        chk_ctl("t6.re.done", 1, 1, 0, 1);
        tick();
        chk_ctl("t6.re.idle", 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
